// File: rtl/ysyx_25020037_mdu_ctrl.sv
// ysyx_25020037_mdu_ctrl
//   Sequencer for the RV32M multiply/divide unit that sits beside the EXU.
//   The unit accepts one operation at a time, runs an iterative shift-add
//   multiplier or a restoring divider for XLEN cycles, and holds the result
//   until the EXU takes it.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset, aborts any operation in flight
//   in_valid   EXU presents an operation
//   in_ready   controller is idle and can accept
//   op         funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   src1/src2  rs1/rs2 operands
//   out_valid  result valid, held until out_ready
//   out_ready  EXU consumes the result
//   result     final result
//   busy       high while an operation is being computed or held
module ysyx_25020037_mdu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            s1neg;
    logic            s2neg;
    logic            special;
    logic [XLEN-1:0] spec_res;
    // hi/lo form the double-width product during a multiply; during a divide
    // hi is the partial remainder and lo shifts the dividend out while the
    // quotient bits shift in.
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] b_q;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    // Operand conditioning on the accept cycle
    logic            sign1;
    logic            sign2;
    logic            n1;
    logic            n2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] spec_val;

    always_comb begin
        sign1    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        sign2    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        n1       = src1[XLEN-1] & sign1;
        n2       = src2[XLEN-1] & sign2;
        mag1     = cond_neg(src1, n1);
        mag2     = cond_neg(src2, n2);
        div0     = op[2] && (src2 == '0);
        ovf      = ((op == OP_DIV) || (op == OP_REM)) && (src1 == INT_MIN) && (src2 == '1);
        // op[1] separates REM/REMU from DIV/DIVU
        if (div0) begin
            spec_val = op[1] ? src1 : '1;
        end else begin
            spec_val = op[1] ? '0 : INT_MIN;
        end
    end

    // One multiply or divide iteration
    logic [XLEN:0]     sum;
    logic [XLEN:0]     shifted;
    logic              ge;
    logic [XLEN-1:0]   diff;
    logic [XLEN-1:0]   hi_nx;
    logic [XLEN-1:0]   lo_nx;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fin;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        shifted = {hi, lo[XLEN-1]};
        ge      = shifted >= {1'b0, b_q};
        // Only the low XLEN bits matter: when ge holds the difference is below b_q.
        diff    = shifted[XLEN-1:0] - b_q;
        if (op_q[2]) begin
            hi_nx = ge ? diff : shifted[XLEN-1:0];
            lo_nx = {lo[XLEN-2:0], ge};
        end else begin
            hi_nx = sum[XLEN:1];
            lo_nx = {sum[0], lo[XLEN-1:1]};
        end
        prod_fix = cond_neg2({hi_nx, lo_nx}, s1neg ^ s2neg);
        quo_fix  = cond_neg(lo_nx, s1neg ^ s2neg);
        rem_fix  = cond_neg(hi_nx, s1neg);
        case (op_q)
            OP_MUL:                     fin = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                   fin = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            fin = quo_fix;
            OP_REM, OP_REMU:            fin = rem_fix;
            default:                    fin = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            cnt       <= '0;
            special   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= S_CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        op_q     <= op;
                        s1neg    <= n1;
                        s2neg    <= n2;
                        special  <= div0 | ovf;
                        spec_res <= spec_val;
                        hi       <= '0;
                        lo       <= mag1;
                        b_q      <= mag2;
                    end
                end
                S_CALC: begin
                    if (special) begin
                        // Divide-by-zero and overflow skip the iterations and
                        // complete on the first edge after accept.
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= spec_res;
                    end else begin
                        hi <= hi_nx;
                        lo <= lo_nx;
                        if (cnt == CNT_LAST) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= fin;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_mdu_ctrl.sv
// Testbench for ysyx_25020037_mdu_ctrl: directed operations checked against
// an arithmetic reference model, with handshake, latency, hold and reset checks.
module tb_ysyx_25020037_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic        active;
    logic [31:0] exp_q;

    ysyx_25020037_mdu_ctrl #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference results straight from RV32M arithmetic definitions
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                sp = sa / sb;
                return sp[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                sp = sa % sb;
                return sp[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 32;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Result must match the model on every cycle it is presented
    always @(negedge clk) begin
        if (active && out_valid) begin
            chk("result", result, exp_q);
            chk("busy_in_done", {31'b0, busy}, 32'd1);
        end
    end

    task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hand, input bit pin,
                         input int stall, input bit pulse);
        int w;
        int lat;
        if (pin) chk({name, "_model"}, model(o, a, b), hand);
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk({name, "_ready_timeout"}, {31'b0, in_ready}, 32'd1);
        op       = o;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        exp_q    = hand;
        active   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        src1     = $urandom;
        src2     = $urandom;
        op       = 3'($urandom);
        chk({name, "_in_ready_busy"}, {30'b0, in_ready, busy}, 32'd1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (pulse && lat == 5) in_valid = 1'b1;
            if (pulse && lat == 6) in_valid = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, model_lat(o, a, b));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({name, "_hold"}, {30'b0, in_ready, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        active    = 1'b0;
        chk({name, "_release"}, {29'b0, out_valid, in_ready, busy}, 32'd2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        src1      = '0;
        src2      = '0;
        active    = 1'b0;
        exp_q     = '0;
        repeat (3) @(negedge clk);
        chk("reset_flags", {29'b0, in_ready, out_valid, busy}, 32'd4);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("mul_7x6",      3'd0, 32'd7,          32'd6,          32'd42,         1, 0, 0);
        do_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1, 10, 0);
        do_op("mulh_m1x2",    3'd1, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  1, 0, 0);
        do_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1, 0, 0);
        do_op("mul_m3x5",     3'd0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  1, 0, 0);
        do_op("mulh_min2",    3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  1, 0, 0);
        do_op("mulhsu_min",   3'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1, 0, 0);
        do_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1, 0, 0);
        do_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1, 0, 0);
        do_op("div_7_m2",     3'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1, 0, 0);
        do_op("rem_7_m2",     3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1,          1, 0, 0);
        do_op("div_min_2",    3'd4, 32'h8000_0000,  32'd2,          32'hC000_0000,  1, 0, 0);
        do_op("divu_100_7",   3'd5, 32'd100,        32'd7,          32'd14,         1, 0, 1);
        do_op("remu_100_7",   3'd7, 32'd100,        32'd7,          32'd2,          1, 3, 0);
        do_op("div_by0",      3'd4, 32'd1234,       32'd0,          32'hFFFF_FFFF,  1, 0, 0);
        do_op("rem_5_by0",    3'd6, 32'd5,          32'd0,          32'd5,          1, 2, 0);
        do_op("divu_by0",     3'd5, 32'd9,          32'd0,          32'hFFFF_FFFF,  1, 0, 0);
        do_op("remu_by0",     3'd7, 32'd9,          32'd0,          32'd9,          1, 0, 0);
        do_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1, 0, 0);
        do_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1, 0, 0);

        for (int k = 0; k < 8; k++) begin
            ro = 3'(k);
            ra = $urandom;
            rb = $urandom;
            do_op("mixed", ro, ra, rb, model(ro, ra, rb), 0, 0, 0);
        end

        // Abort an operation part way through its iterations
        while (!in_ready) @(negedge clk);
        op       = 3'd0;
        src1     = 32'd3;
        src2     = 32'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_in_calc", {29'b0, in_ready, out_valid, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_flags", {29'b0, in_ready, out_valid, busy}, 32'd4);
        chk("abort_result", result, 32'd0);
        do_op("after_abort",  3'd5, 32'd100,        32'd7,          32'd14,         1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
